// File: rtl/cam_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// cam_i2c_arbiter
//   Shares one camera I2C write master between N_REQ requesters, for example
//   the cam0/cam1 init sequencers and the runtime exposure controller.
//   Requesters are served round-robin, with one register write per grant.
//   The block latches the winner's payload and drives the master's
//   send_data/ready handshake. When the write finishes it pulses a
//   per-requester done.
//
// Optional feature macro: CAM_I2C_TIMEOUT_EN
//   When defined, each wait state is bounded by TIMEOUT_CYC cycles. An
//   expired wait aborts the write with an err pulse.
//   When undefined, the wait states wait forever and err is tied to 0.
//
// Ports
//   clk400        in   400 kHz I2C system clock
//   reset_n       in   asynchronous active-low reset
//   req           in   per-requester level request, held until done/err
//   req_slave     in   slave address, requester i at [8i+7:8i]
//   req_reg       in   register address, requester i at [16i+15:16i]
//   req_data      in   write data, requester i at [8i+7:8i]
//   done          out  one-cycle pulse, write of the granted requester completed
//   err           out  one-cycle pulse, write of the granted requester timed out
//   busy          out  a transaction is in progress
//   m_send_data   out  one-cycle start pulse to the I2C master
//   m_slave_addr  out  latched slave address
//   m_register_in out  latched register address
//   m_datain      out  latched write data
//   m_ready       in   master ready, low while a transfer runs
// ---------------------------------------------------------------------------
module cam_i2c_arbiter #(
    parameter int N_REQ       = 2,
    parameter int TIMEOUT_CYC = 4000
) (
    input  logic                  clk400,
    input  logic                  reset_n,
    input  logic [N_REQ-1:0]      req,
    input  logic [8*N_REQ-1:0]    req_slave,
    input  logic [16*N_REQ-1:0]   req_reg,
    input  logic [8*N_REQ-1:0]    req_data,
    output logic [N_REQ-1:0]      done,
    output logic [N_REQ-1:0]      err,
    output logic                  busy,
    output logic                  m_send_data,
    output logic [7:0]            m_slave_addr,
    output logic [15:0]           m_register_in,
    output logic [7:0]            m_datain,
    input  logic                  m_ready
);

    localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_LO,
        WAIT_HI
    } state_t;

    state_t          state;
    logic [GW-1:0]   rr;
    logic [GW-1:0]   grant;
    logic [GW-1:0]   pick;
    logic            found;
    int              idx;

`ifdef CAM_I2C_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0]     cnt;
`endif

    // Search starts just after the last winner and wraps, so the most
    // recently served requester has the lowest priority.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr) + k) % N_REQ;
            if (!found && req[idx[GW-1:0]]) begin
                found = 1'b1;
                pick  = idx[GW-1:0];
            end
        end
    end

    assign busy = (state != IDLE);

    // The master must report ready before a grant is made. Otherwise it may
    // still be finishing a transfer started elsewhere.
    always_ff @(posedge clk400 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            rr            <= GW'(N_REQ - 1);
            grant         <= '0;
            done          <= '0;
            m_send_data   <= 1'b0;
            m_slave_addr  <= '0;
            m_register_in <= '0;
            m_datain      <= '0;
`ifdef CAM_I2C_TIMEOUT_EN
            err           <= '0;
            cnt           <= '0;
`endif
        end else begin
            m_send_data <= 1'b0;
            done        <= '0;
`ifdef CAM_I2C_TIMEOUT_EN
            err         <= '0;
`endif
            case (state)
                IDLE: begin
                    if (found && m_ready) begin
                        m_slave_addr  <= req_slave[int'(pick)*8 +: 8];
                        m_register_in <= req_reg[int'(pick)*16 +: 16];
                        m_datain      <= req_data[int'(pick)*8 +: 8];
                        grant         <= pick;
                        rr            <= pick;
                        m_send_data   <= 1'b1;
                        state         <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_LO;
`ifdef CAM_I2C_TIMEOUT_EN
                    cnt   <= '0;
`endif
                end
                WAIT_LO: begin
                    if (!m_ready) begin
                        state <= WAIT_HI;
`ifdef CAM_I2C_TIMEOUT_EN
                        cnt   <= '0;
                    end else if (cnt == TIMEOUT_LAST) begin
                        err[grant] <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
`endif
                    end
                end
                WAIT_HI: begin
                    if (m_ready) begin
                        done[grant] <= 1'b1;
                        state       <= IDLE;
`ifdef CAM_I2C_TIMEOUT_EN
                    end else if (cnt == TIMEOUT_LAST) begin
                        err[grant] <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef CAM_I2C_TIMEOUT_EN
    assign err = '0;
`endif

endmodule

// File: tb/tb_cam_i2c_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cam_i2c_arbiter
//   Self-checking bench for cam_i2c_arbiter with N_REQ = 2.
//   A behavioural I2C master model answers each send_data pulse.
//   A monitor predicts the round-robin winner from the request snapshot
//   taken at the grant edge and checks the latched payload. It then queues
//   the expected done/err, and pops that entry when the pulse appears.
//   Directed scenarios run first, followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_cam_i2c_arbiter;

    localparam int N_REQ = 2;
`ifdef CAM_I2C_TIMEOUT_EN
    localparam int TB_TIMEOUT = 32;
`else
    localparam int TB_TIMEOUT = 4000;
`endif

    logic                  clk400 = 1'b0;
    logic                  reset_n;
    logic [N_REQ-1:0]      req;
    logic [8*N_REQ-1:0]    req_slave;
    logic [16*N_REQ-1:0]   req_reg;
    logic [8*N_REQ-1:0]    req_data;
    logic [N_REQ-1:0]      done;
    logic [N_REQ-1:0]      err;
    logic                  busy;
    logic                  m_send_data;
    logic [7:0]            m_slave_addr;
    logic [15:0]           m_register_in;
    logic [7:0]            m_datain;
    logic                  m_ready;

    cam_i2c_arbiter #(.N_REQ(N_REQ), .TIMEOUT_CYC(TB_TIMEOUT)) dut (
        .clk400        (clk400),
        .reset_n       (reset_n),
        .req           (req),
        .req_slave     (req_slave),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .done          (done),
        .err           (err),
        .busy          (busy),
        .m_send_data   (m_send_data),
        .m_slave_addr  (m_slave_addr),
        .m_register_in (m_register_in),
        .m_datain      (m_datain),
        .m_ready       (m_ready)
    );

    always #5 clk400 = ~clk400;

    typedef struct {
        int idx;
        bit is_err;
    } exp_t;

    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    send_count = 0;
    int    resp_count = 0;
    int    model_rr = N_REQ - 1;
    int    master_mode = 0;
    int    d1 = 3;
    int    d2 = 20;

    logic [N_REQ-1:0]    req_q;
    logic [8*N_REQ-1:0]  slave_q;
    logic [16*N_REQ-1:0] reg_q;
    logic [8*N_REQ-1:0]  data_q;

    // Request and payload as the DUT saw them at the most recent rising edge.
    always @(posedge clk400) begin
        req_q   <= req;
        slave_q <= req_slave;
        reg_q   <= req_reg;
        data_q  <= req_data;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int i, input logic [7:0] s, input logic [15:0] r, input logic [7:0] d);
        req_slave[8*i +: 8]  = s;
        req_reg[16*i +: 16]  = r;
        req_data[8*i +: 8]   = d;
        req[i]               = 1'b1;
    endtask

    task automatic wait_resp(input int budget, output int who);
        who = -1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk400);
            if ((|done) || (|err)) begin
                for (int i = 0; i < N_REQ; i++)
                    if (done[i] || err[i]) who = i;
                break;
            end
        end
        check_output("resp_within_budget", 32'(who >= 0), 32'd1);
    endtask

    // Master model.
    //   Mode 0 answers every send_data: ready drops after d1 cycles and
    //   rises again after a further d2 cycles.
    //   Mode 1 holds ready high and never answers.
    //   Mode 2 holds ready low.
    initial begin
        int c;
        m_ready = 1'b1;
        forever begin
            @(negedge clk400);
            if (!reset_n) begin
                m_ready = 1'b1;
            end else if (master_mode == 1) begin
                m_ready = 1'b1;
            end else if (master_mode == 2) begin
                m_ready = 1'b0;
            end else begin
                m_ready = 1'b1;
                if (m_send_data) begin
                    c = 0;
                    while (c < d1 && reset_n) begin @(negedge clk400); c++; end
                    if (reset_n) begin
                        m_ready = 1'b0;
                        c = 0;
                        while (c < d2 && reset_n) begin @(negedge clk400); c++; end
                    end
                    m_ready = 1'b1;
                end
            end
        end
    end

    // Monitor and scoreboard: predicts grants, then checks completions.
    initial begin
        int   win;
        int   idx;
        exp_t e;
        logic [N_REQ-1:0] ed;
        logic [N_REQ-1:0] ee;
        forever begin
            @(negedge clk400);
            if (!reset_n) begin
                exp_q.delete();
                model_rr = N_REQ - 1;
            end else begin
                if (m_send_data) begin
                    send_count++;
                    win = -1;
                    for (int k = 1; k <= N_REQ; k++) begin
                        idx = (model_rr + k) % N_REQ;
                        if (win < 0 && req_q[idx]) win = idx;
                    end
                    check_output("grant_has_request", 32'(win >= 0), 32'd1);
                    check_output("busy_at_issue", 32'(busy), 32'd1);
                    if (win >= 0) begin
                        check_output("slave_addr", 32'(m_slave_addr), 32'(slave_q[8*win +: 8]));
                        check_output("register_in", 32'(m_register_in), 32'(reg_q[16*win +: 16]));
                        check_output("datain", 32'(m_datain), 32'(data_q[8*win +: 8]));
                        model_rr = win;
                        e.idx = win;
`ifdef CAM_I2C_TIMEOUT_EN
                        e.is_err = (master_mode == 1);
`else
                        e.is_err = 1'b0;
`endif
                        exp_q.push_back(e);
                    end
                end
                if ((|done) || (|err)) begin
                    resp_count++;
                    if (exp_q.size() == 0) begin
                        check_output("unexpected_resp", 32'({done, err}), 32'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        ed = '0;
                        ee = '0;
                        if (e.is_err) ee[e.idx] = 1'b1;
                        else          ed[e.idx] = 1'b1;
                        check_output("done_vector", 32'(done), 32'(ed));
                        check_output("err_vector", 32'(err), 32'(ee));
                    end
                end
            end
        end
    end

    // Directed scenarios followed by a randomized phase.
    initial begin
        int who;
        int s0;
        int r0;
        int lat;
        int order[4];
        int resp;
        int cyc;
        logic [7:0] sv;

        reset_n   = 1'b0;
        req       = '0;
        req_slave = '0;
        req_reg   = '0;
        req_data  = '0;
        #1;
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_send", 32'(m_send_data), 32'd0);
        check_output("rst_done", 32'(done), 32'd0);
        check_output("rst_err", 32'(err), 32'd0);
        check_output("rst_slave", 32'(m_slave_addr), 32'd0);
        check_output("rst_reg", 32'(m_register_in), 32'd0);
        check_output("rst_data", 32'(m_datain), 32'd0);
        repeat (2) @(negedge clk400);
        reset_n = 1'b1;
        repeat (2) @(negedge clk400);

        $display("[TB] single write from requester 0");
        d1 = 3; d2 = 20;
        s0 = send_count; r0 = resp_count;
        apply_stimulus(0, 8'h10, 16'h3008, 8'h82);
        wait_resp(100, who);
        check_output("t1_who", 32'(who), 32'd0);
        req[0] = 1'b0;
        check_output("t1_slave", 32'(m_slave_addr), 32'h10);
        check_output("t1_reg", 32'(m_register_in), 32'h3008);
        check_output("t1_data", 32'(m_datain), 32'h82);
        repeat (10) @(negedge clk400);
        check_output("t1_sends", 32'(send_count - s0), 32'd1);
        check_output("t1_resps", 32'(resp_count - r0), 32'd1);

        $display("[TB] two held requests alternate");
        d1 = 1; d2 = 4;
        apply_stimulus(0, 8'h20, 16'h0100, 8'h11);
        apply_stimulus(1, 8'h30, 16'h0200, 8'h22);
        for (int k = 0; k < 4; k++) begin
            wait_resp(100, who);
            order[k] = who;
            if (who >= 0) begin
                sv = req_slave[8*who +: 8];
                check_output("t2_payload_slave", 32'(m_slave_addr), 32'(sv));
                req_slave[8*who +: 8] = 8'($urandom);
                req_reg[16*who +: 16] = 16'($urandom);
                req_data[8*who +: 8]  = 8'($urandom);
            end
            if (k > 0) check_output("t2_alternate", 32'(order[k]), 32'(1 - order[k-1]));
        end
        req = '0;
        repeat (6) @(negedge clk400);
        check_output("t2_idle", 32'(busy), 32'd0);

        $display("[TB] request dropped while waiting for ready high");
        d1 = 2; d2 = 12;
        s0 = send_count;
        apply_stimulus(0, 8'h44, 16'h1234, 8'h56);
        cyc = 0;
        while (m_ready && cyc < 50) begin @(negedge clk400); cyc++; end
        @(negedge clk400);
        req[0] = 1'b0;
        wait_resp(100, who);
        check_output("t3_who", 32'(who), 32'd0);
        repeat (10) @(negedge clk400);
        check_output("t3_sends", 32'(send_count - s0), 32'd1);

        $display("[TB] asynchronous reset mid-transfer");
        d1 = 2; d2 = 20;
        apply_stimulus(0, 8'h55, 16'h4321, 8'h99);
        cyc = 0;
        while (m_ready && cyc < 50) begin @(negedge clk400); cyc++; end
        repeat (2) @(negedge clk400);
        check_output("t4_busy_before", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        req = '0;
        #1;
        check_output("t4_busy", 32'(busy), 32'd0);
        check_output("t4_send", 32'(m_send_data), 32'd0);
        check_output("t4_slave", 32'(m_slave_addr), 32'd0);
        check_output("t4_reg", 32'(m_register_in), 32'd0);
        check_output("t4_data", 32'(m_datain), 32'd0);
        repeat (2) @(negedge clk400);
        apply_stimulus(1, 8'h66, 16'h7788, 8'h3c);
        #2;
        reset_n = 1'b1;
        s0 = send_count;
        lat = 0;
        while (send_count == s0 && lat < 4) begin @(negedge clk400); lat++; end
        check_output("t4_latency", 32'(lat >= 1 && lat <= 2), 32'd1);
        wait_resp(100, who);
        check_output("t4_who", 32'(who), 32'd1);
        req[1] = 1'b0;
        repeat (4) @(negedge clk400);

        $display("[TB] master never drops ready");
        d1 = 2; d2 = 4;
        master_mode = 1;
        s0 = send_count;
        apply_stimulus(0, 8'h71, 16'h0a0a, 8'h01);
        apply_stimulus(1, 8'h72, 16'h0b0b, 8'h02);
`ifdef CAM_I2C_TIMEOUT_EN
        wait_resp(200, who);
        check_output("t5_first_err", 32'(who), 32'd0);
        if (who >= 0) req[who] = 1'b0;
        wait_resp(200, who);
        check_output("t5_second_err", 32'(who), 32'd1);
        if (who >= 0) req[who] = 1'b0;
        master_mode = 0;
`else
        repeat (30) @(negedge clk400);
        check_output("t5_busy_hung", 32'(busy), 32'd1);
        check_output("t5_err_zero", 32'(err), 32'd0);
        check_output("t5_one_send", 32'(send_count - s0), 32'd1);
        master_mode = 2;
        repeat (3) @(negedge clk400);
        master_mode = 1;
        wait_resp(50, who);
        check_output("t5_first_done", 32'(who), 32'd0);
        req[0] = 1'b0;
        master_mode = 0;
        wait_resp(100, who);
        check_output("t5_second_done", 32'(who), 32'd1);
        req[1] = 1'b0;
`endif
        repeat (4) @(negedge clk400);

        $display("[TB] no grant while master not ready");
        master_mode = 2;
        repeat (2) @(negedge clk400);
        s0 = send_count;
        apply_stimulus(0, 8'h81, 16'h5555, 8'haa);
        repeat (10) @(negedge clk400);
        check_output("t6_busy", 32'(busy), 32'd0);
        check_output("t6_no_send", 32'(send_count - s0), 32'd0);
        master_mode = 0;
        wait_resp(100, who);
        check_output("t6_who", 32'(who), 32'd0);
        req[0] = 1'b0;
        repeat (4) @(negedge clk400);

        $display("[TB] randomized traffic");
        resp = 0;
        cyc  = 0;
        while (resp < 30 && cyc < 3000) begin
            @(negedge clk400);
            cyc++;
            d1 = $urandom_range(1, 4);
            d2 = $urandom_range(1, 6);
            for (int i = 0; i < N_REQ; i++) begin
                if (done[i] || err[i]) begin
                    resp++;
                    if ($urandom_range(0, 1) == 0) begin
                        req[i] = 1'b0;
                    end else begin
                        req_slave[8*i +: 8] = 8'($urandom);
                        req_reg[16*i +: 16] = 16'($urandom);
                        req_data[8*i +: 8]  = 8'($urandom);
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    apply_stimulus(i, 8'($urandom), 16'($urandom), 8'($urandom));
                end
            end
        end
        check_output("random_progress", 32'(resp >= 30), 32'd1);
        req = '0;
        repeat (40) @(negedge clk400);
        check_output("drain_busy", 32'(busy), 32'd0);
        check_output("drain_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
